// File: rtl/delay_line_ctrl.sv
// Sequencer for a DEPTH-stage zero-flushed delay line: frames samples in, pads DEPTH zeros, qualifies dout0.
// Optional frame statistics (frame_cnt, len_err) are compiled in with `define DLC_FRAME_STAT_EN.
module delay_line_ctrl #(
    parameter int DEPTH   = 31,
    parameter int MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        sr_valid,
    output logic        sr_zero,
    output logic        out_valid,
    output logic        out_last,
    output logic        busy
`ifdef DLC_FRAME_STAT_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [0:0]  len_err
`endif
);

    localparam int CNT_W = $clog2(MAX_LEN + DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // a shift of the line always consumes the current dout0, so shifting needs out_ready | ~out_valid.
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] shift_idx;
    logic [CNT_W-1:0] end_idx;
    logic             can_shift;
    logic             in_fire;
    logic             at_max;
    logic             frame_cut;
    logic             at_end;

    assign can_shift = out_ready | ~out_valid;
    assign in_ready  = (state != FLUSH) & can_shift;
    assign in_fire   = in_valid & in_ready;
    assign sr_zero   = (state == FLUSH);
    assign sr_valid  = in_fire | (sr_zero & can_shift);
    assign busy      = (state != IDLE);

    assign at_max    = (shift_idx == CNT_W'(MAX_LEN - 1));
    assign frame_cut = in_fire & (in_last | at_max);
    assign at_end    = sr_zero & (shift_idx == end_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN: begin
                if (frame_cut)
                    state_nxt = FLUSH;
                else if (in_fire)
                    state_nxt = RUN;
            end
            FLUSH: begin
                if (sr_valid && at_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_idx <= '0;
            end_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (sr_valid)
                shift_idx <= at_end ? '0 : shift_idx + CNT_W'(1);
            // end_idx = L + DEPTH - 1 with L = shift_idx + 1 at the cutting sample
            if (frame_cut)
                end_idx <= shift_idx + CNT_W'(DEPTH);
            if (sr_valid) begin
                out_valid <= (shift_idx >= CNT_W'(DEPTH));
                out_last  <= at_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef DLC_FRAME_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            len_err   <= 1'b0;
        end else begin
            if (out_valid && out_last && out_ready)
                frame_cnt <= frame_cnt + 16'd1;
            if (frame_cut && !in_last)
                len_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: wraps the controller with a delay-line model and scoreboards dout0.
module tb_delay_line_ctrl;

    localparam int DEPTH   = 4;
    localparam int MAX_LEN = 16;
    localparam int DW      = 16;
    localparam int W       = DW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic          ready_toggle = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, sr_valid, sr_zero, out_valid, out_last, busy;
    logic [DW-1:0] stage [DEPTH];
    logic [DW-1:0] dout0;
`ifdef DLC_FRAME_STAT_EN
    logic [15:0]   frame_cnt;
    logic [0:0]    len_err;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [W-1:0] exp_q[$];

    int shift_cnt, zero_cnt, out_cnt, last_cnt, first_ov, fire_cnt;
    int blocked_cnt, b2b_seen, stall_cnt;
    logic stalled = 1'b0;
    logic [DW-1:0] held_dout;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    delay_line_ctrl #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .sr_valid  (sr_valid),
        .sr_zero   (sr_zero),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy)
`ifdef DLC_FRAME_STAT_EN
        ,
        .frame_cnt (frame_cnt),
        .len_err   (len_err)
`endif
    );

    // Delay line under control: DEPTH stages followed by the registered dout0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            dout0 <= '0;
        end else if (sr_valid) begin
            stage[0] <= sr_zero ? '0 : in_data;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            dout0 <= stage[DEPTH-1];
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = ready_toggle ? ~out_ready : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] d, input logic lst, input logic exp_last);
        int  guard = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = lst;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({exp_last, d});
                done = 1;
            end
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 100) begin
                check("accept_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear_stats();
        shift_cnt = 0; zero_cnt = 0; out_cnt = 0; last_cnt = 0; first_ov = -1;
        fire_cnt = 0; blocked_cnt = 0; b2b_seen = 0; stall_cnt = 0;
    endtask

    task automatic wait_done();
        int  guard = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            if (!busy && !out_valid && exp_q.size() == 0) done = 1;
            guard++;
            if (!done && guard > 400) begin
                check("drain_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            if (sr_zero) check("in_ready_in_flush", in_ready, 1'b0);
            if (stalled) begin
                check("hold_out_valid", out_valid, 1'b1);
                check("hold_dout0", dout0, held_dout);
            end
            stalled   = out_valid && !out_ready;
            held_dout = dout0;
            if (stalled) begin
                stall_cnt++;
                check("no_shift_while_stalled", sr_valid, 1'b0);
            end
            if (out_valid && first_ov < 0) first_ov = shift_cnt;
            if (sr_valid) begin
                shift_cnt++;
                if (sr_zero) zero_cnt++;
            end
            if (in_valid && in_ready) fire_cnt++;
            if (sr_zero && in_valid && !in_ready) blocked_cnt++;
            if (in_valid && in_ready && out_valid && out_last && out_ready) b2b_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_output: got %0h expected no output at %0t", dout0, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", dout0, e[DW-1:0]);
                    check("out_last", out_last, e[DW]);
                    out_cnt++;
                    if (out_last) last_cnt++;
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sr_valid", sr_valid, 1'b0);
`ifdef DLC_FRAME_STAT_EN
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_len_err", len_err, 1'b0);
`endif
        @(posedge clk);
        #1;

        // in_last without in_valid is ignored
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
        check("stray_last_busy", busy, 1'b0);

        // L=6 continuous
        clear_stats();
        for (int k = 0; k < 6; k++) send(16'h1000 + 16'(k), k == 5, k == 5);
        idle_in();
        wait_done();
        check("l6_fire", fire_cnt, 6);
        check("l6_zero_shifts", zero_cnt, DEPTH);
        check("l6_shifts", shift_cnt, 6 + DEPTH);
        check("l6_first_valid_shift", first_ov, DEPTH + 1);
        check("l6_outputs", out_cnt, 6);
        check("l6_lasts", last_cnt, 1);
        check("l6_busy_after", busy, 1'b0);

        // L=2, shorter than the line
        clear_stats();
        send(16'h2001, 1'b0, 1'b0);
        send(16'h2002, 1'b1, 1'b1);
        idle_in();
        wait_done();
        check("l2_zero_shifts", zero_cnt, DEPTH);
        check("l2_first_valid_shift", first_ov, DEPTH + 1);
        check("l2_outputs", out_cnt, 2);
        check("l2_lasts", last_cnt, 1);

        // L=8 with out_ready toggling
        clear_stats();
        ready_toggle = 1'b1;
        for (int k = 0; k < 8; k++) send(16'h5000 + 16'(k), k == 7, k == 7);
        idle_in();
        wait_done();
        ready_toggle = 1'b0;
        check("bp_outputs", out_cnt, 8);
        check("bp_lasts", last_cnt, 1);
        check("bp_stalls_seen", stall_cnt > 0, 1'b1);

        // in_valid held through FLUSH; next frame starts as out_last is consumed
        clear_stats();
        for (int k = 0; k < 3; k++) send(16'h6000 + 16'(k), k == 2, k == 2);
        send(16'h6100, 1'b0, 1'b0);
        send(16'h6101, 1'b1, 1'b1);
        idle_in();
        wait_done();
        check("flush_blocked_cycles", blocked_cnt, DEPTH);
        check("b2b_accept_on_last", b2b_seen, 1);
        check("flush_outputs", out_cnt, 5);
        check("flush_lasts", last_cnt, 2);

        // 20 samples, first in_last on the 20th: cut at 16, then a 4-sample frame
        clear_stats();
        for (int k = 0; k < 20; k++) send(16'h3000 + 16'(k), k == 19, (k == 15) || (k == 19));
        idle_in();
        wait_done();
        check("trunc_outputs", out_cnt, 20);
        check("trunc_lasts", last_cnt, 2);
`ifdef DLC_FRAME_STAT_EN
        check("trunc_len_err", len_err, 1'b1);
        check("frame_cnt_total", frame_cnt, 16'd7);
`endif

        // reset in the middle of a frame
        clear_stats();
        send(16'h4000, 1'b0, 1'b0);
        send(16'h4001, 1'b0, 1'b0);
        in_data = 16'h4002;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        idle_in();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        clear_stats();
        for (int k = 0; k < 5; k++) send(16'h7000 + 16'(k), k == 4, k == 4);
        idle_in();
        wait_done();
        check("post_rst_outputs", out_cnt, 5);
        check("post_rst_lasts", last_cnt, 1);
`ifdef DLC_FRAME_STAT_EN
        check("post_rst_frame_cnt", frame_cnt, 16'd1);
        check("post_rst_len_err", len_err, 1'b0);
`endif
        check("queue_empty_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
